// File: rtl/repo_reader.sv
// Streams word_count words from the repository starting at base_addr into a small output FIFO; first word leaves READ_LATENCY+1 cycles after start.
// Backpressure: issue is credit-gated on fifo_count+inflight<FIFO_DEPTH, so a stalled consumer halts address generation without loss.

module repo_reader_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push_vld,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop_rdy,
   output logic                     head_vld,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign head_vld = (count != '0);
   assign head_dat = head_vld ? store[rd_ptr] : '0;
   assign do_pop   = pop_rdy && head_vld;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push  = push_vld && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush) store[wr_ptr] <= push_dat;
   end
endmodule

module repo_reader #(
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [29:0] base_addr,
   input  logic [15:0] word_count,
   output logic [29:0] mem_addr,
   input  logic [31:0] data_read,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        error
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]              state;
   logic [1:0]              state_nxt;
   logic [15:0]             count_q;
   logic [15:0]             issued;
   logic [15:0]             popped;
   logic [READ_LATENCY-1:0] vld_sr;
   logic [CW-1:0]           fifo_count;
   logic [CW-1:0]           inflight;
   logic [CW:0]             credit_used;

   logic in_xfer;
   logic abort_act;
   logic aligned;
   logic start_acc;
   logic start_go;
   logic fetch_issue;
   logic last_issue;
   logic issue;
   logic push;
   logic pop;
   logic drain_done;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_sr[i]);
   end

   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
   assign in_xfer     = (state == ST_FETCH) || (state == ST_DRAIN);
   assign abort_act   = abort && in_xfer;
   assign aligned     = (base_addr[1:0] == 2'b00);
   assign start_acc   = (state == ST_IDLE) && start && aligned;
   assign start_go    = start_acc && (word_count != 16'd0);
   assign fetch_issue = (state == ST_FETCH) && !abort && (issued < count_q) &&
                        (credit_used < (CW+1)'(FIFO_DEPTH));
   assign last_issue  = fetch_issue && ((issued + 16'd1) == count_q);
   assign issue       = start_go || fetch_issue;
   assign push        = vld_sr[READ_LATENCY-1] && !abort_act;
   assign pop         = out_valid && out_ready;
   assign drain_done  = (inflight == '0) && (fifo_count == '0) && (popped == count_q);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_acc) state_nxt = (word_count == 16'd0) ? ST_DONE : ST_FETCH;
         // A single-word transfer issues on the start edge, so FETCH can already be complete.
         ST_FETCH: if (abort) state_nxt = ST_IDLE;
                   else if (last_issue || (issued == count_q)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (abort) state_nxt = ST_IDLE;
                   else if (drain_done) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         mem_addr <= '0;
         count_q  <= '0;
         issued   <= '0;
         popped   <= '0;
         error    <= 1'b0;
      end else begin
         state <= state_nxt;
         error <= (state == ST_IDLE) && start && !aligned;
         if (start_go)         mem_addr <= base_addr;
         else if (fetch_issue) mem_addr <= mem_addr + 30'd4;
         if (start_acc) begin
            count_q <= word_count;
            issued  <= start_go ? 16'd1 : 16'd0;
            popped  <= '0;
         end else begin
            if (fetch_issue)     issued <= issued + 16'd1;
            if (pop && in_xfer)  popped <= popped + 16'd1;
         end
      end
   end

   // Each issue is tagged here and lands in the FIFO exactly READ_LATENCY edges later.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_sr <= '0;
      end else if (abort_act) begin
         vld_sr <= '0;
      end else begin
         for (int i = READ_LATENCY - 1; i > 0; i--) vld_sr[i] <= vld_sr[i-1];
         vld_sr[0] <= issue;
      end
   end

   repo_reader_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (abort_act),
      .push_vld (push),
      .push_dat (data_read),
      .pop_rdy  (out_ready),
      .head_vld (out_valid),
      .head_dat (out_data),
      .count    (fifo_count)
   );

   assign busy = in_xfer;
   assign done = (state == ST_DONE);
endmodule

// File: tb/tb_repo_reader.sv
// Directed and randomized transfers against a repository model; expected words and addresses come from base+4*i arithmetic.
module tb_repo_reader;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        out_ready = 1'b0;
   logic [29:0] base_addr = '0;
   logic [15:0] word_count = '0;
   logic [29:0] mem_addr;
   logic [31:0] data_read;
   logic [31:0] out_data;
   logic        out_valid;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [21:0] idx);
      return {10'b0, idx} * 32'h9E37_79B1 + 32'h0BAD_F00D;
   endfunction

   assign data_read = mem_word(mem_addr[23:2]);

   repo_reader #(
      .READ_LATENCY (1),
      .FIFO_DEPTH   (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_addr   (mem_addr),
      .data_read  (data_read),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int          cyc = 0;
   logic [31:0] got_q[$];
   logic [29:0] addr_q[$];
   int          addr_cyc_q[$];
   logic [29:0] prev_addr = '0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          err_cnt = 0;
   int          err_cyc = -1;
   bit          busy_seen = 1'b0;
   bit          chk_stable = 1'b0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_d = '0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (mem_addr !== prev_addr) begin
         addr_q.push_back(mem_addr);
         addr_cyc_q.push_back(cyc);
         prev_addr = mem_addr;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (error === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (busy === 1'b1) busy_seen = 1'b1;
      if (chk_stable && hold_v) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", out_data, hold_d);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      addr_q.delete();
      addr_cyc_q.delete();
      prev_addr = mem_addr;
      done_cnt  = 0;
      done_cyc  = -1;
      err_cnt   = 0;
      err_cyc   = -1;
      busy_seen = 1'b0;
   endtask

   function automatic logic [29:0] pick_base();
      logic [29:0] b;
      b = 30'($urandom) & 30'h3FFF_FFFC;
      if (b == mem_addr) b = b + 30'd64;
      return b;
   endfunction

   task automatic pulse_start(input logic [29:0] b, input logic [15:0] n, output int sc);
      clear_mon();
      base_addr  = b;
      word_count = n;
      start      = 1'b1;
      step();
      start      = 1'b0;
      sc         = cyc;
   endtask

   task automatic run_xfer(input logic [29:0] b, input int n, input int stall, input bit rnd, input bit poke);
      int          sc;
      int          k;
      int          nstall;
      logic [29:0] a;
      chk_stable = 1'b1;
      pulse_start(b, 16'(n), sc);
      k = 0;
      while (done_cnt == 0 && k < 600) begin
         out_ready = (k < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         if (poke && k == 2) begin
            start      = 1'b1;
            base_addr  = ~b & 30'h3FFF_FFFC;
            word_count = 16'd3;
         end
         step();
         start = 1'b0;
         k++;
      end
      check("done_once", 32'(done_cnt), 32'd1);
      check("word_total", 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         a = b + 30'(4 * i);
         check("word_data", got_q[i], mem_word(a[23:2]));
      end
      check("issue_total", 32'(addr_q.size()), 32'(n));
      for (int i = 0; i < n && i < addr_q.size(); i++) begin
         a = b + 30'(4 * i);
         check("issue_addr", 32'(addr_q[i]), 32'(a));
      end
      if (!rnd && stall == 0 && n > 0) begin
         check("done_cycle", 32'(done_cyc), 32'(sc + n + 2));
         for (int i = 0; i < n && i < addr_cyc_q.size(); i++)
            check("issue_cycle", 32'(addr_cyc_q[i]), 32'(sc + i));
      end
      if (stall > 0) begin
         nstall = 0;
         foreach (addr_cyc_q[i]) if (addr_cyc_q[i] < sc + stall) nstall++;
         check("stall_issue_le_depth", 32'(nstall <= 4), 32'd1);
      end
      if (n == 0) check("zero_done_cycle", 32'(done_cyc), 32'(sc));
      check("busy_seen", 32'(busy_seen), 32'(n > 0));
      check("no_error", 32'(err_cnt), 32'd0);
      chk_stable = 1'b0;
   endtask

   initial begin
      int sc;
      int k;
      int na;
      reset = 1'b0;
      #12;
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      reset = 1'b1;
      step();

      // Full-speed 4-word read, then a back-to-back transfer with a stray start mid-flight.
      run_xfer(30'h100, 4, 0, 1'b0, 1'b0);
      run_xfer(30'h200, 5, 0, 1'b0, 1'b1);
      repeat (3) step();

      run_xfer(30'h400, 8, 10, 1'b0, 1'b0);
      repeat (2) step();

      run_xfer(pick_base(), 0, 0, 1'b0, 1'b0);
      repeat (2) step();

      // Misaligned start is rejected without touching the address.
      pulse_start(30'h102, 16'd4, sc);
      repeat (4) step();
      check("err_pulses", 32'(err_cnt), 32'd1);
      check("err_cycle", 32'(err_cyc), 32'(sc));
      check("err_busy", 32'(busy_seen), 32'd0);
      check("err_no_issue", 32'(addr_q.size()), 32'd0);
      check("err_no_done", 32'(done_cnt), 32'd0);
      run_xfer(pick_base(), 3, 0, 1'b0, 1'b0);
      repeat (2) step();

      run_xfer(30'h3FFF_FFF8, 3, 0, 1'b1, 1'b0);
      repeat (2) step();

      for (int t = 0; t < 6; t++) begin
         run_xfer(pick_base(), int'($urandom_range(1, 12)), int'($urandom_range(0, 6)), 1'b1, 1'b0);
         if (t[0]) repeat (2) step();
      end

      // Abort after two words have been consumed.
      out_ready = 1'b1;
      pulse_start(pick_base(), 16'd6, sc);
      k = 0;
      while (got_q.size() < 2 && k < 100) begin
         step();
         k++;
      end
      check("abort_reached_two", 32'(got_q.size()), 32'd2);
      abort     = 1'b1;
      out_ready = 1'b0;
      step();
      abort = 1'b0;
      na    = addr_q.size();
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      out_ready = 1'b1;
      repeat (8) step();
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_no_words", 32'(got_q.size()), 32'd2);
      check("abort_no_issue", 32'(addr_q.size()), 32'(na));
      check("abort_idle_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a stalled transfer.
      out_ready = 1'b0;
      pulse_start(pick_base(), 16'd6, sc);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      check("midrst_mem_addr", 32'(mem_addr), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", out_data, 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      step();
      reset = 1'b1;
      check("midrst_no_done", 32'(done_cnt), 32'd0);
      run_xfer(pick_base(), 6, 0, 1'b0, 1'b0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
